mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Arbiter for the single-ported unified memory shared by the fetch stage and the memory stage of the pipeline. It accepts read requests from instruction fetch and read/write requests from data memory. It serializes them onto one fixed-latency memory port and returns data and a completion pulse to the winning requester. Ties go to the data port, with a starvation guard for fetch. Fetch transactions can be squashed on a branch redirect.

## Interface
- LATENCY, 2: cycles from mem_en to valid mem_rdata; legal range 1..15
- STARVE_MAX, 4: consecutive lost ties after which fetch wins the next tie; legal range 1..15
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- if_req  in  1  fetch read request, level
- if_addr  in  16  fetch address
- if_flush  in  1  cancel in-flight fetch (branch redirect)
- if_grant  out  1  fetch transaction issued this cycle
- if_done  out  1  fetch completion pulse
- if_rdata  out  16  fetch read data, valid with if_done
- dm_req  in  1  data request, level
- dm_wr  in  1  1 = write, 0 = read
- dm_addr  in  16  data address
- dm_wdata  in  16  write data
- dm_grant  out  1  data transaction issued this cycle
- dm_done  out  1  data completion pulse
- dm_rdata  out  16  data read data, valid with dm_done on reads
- mem_en  out  1  memory access strobe, one cycle per transaction
- mem_wr  out  1  memory write enable, qualified by mem_en
- mem_addr  out  16  memory address
- mem_wdata  out  16  memory write data
- mem_rdata  in  16  memory read data, valid exactly LATENCY cycles after mem_en
- busy  out  1  high in every state except IDLE
- err  out  1  unaligned-access flag, pulses with done

## Operation
- States: IDLE, ISSUE, WAIT, DONE. Only one transaction is outstanding at a time.
- IDLE: sample requests.
  - If only one request is present, it wins.
  - If both are present, dm wins unless starve_cnt == STARVE_MAX, in which case fetch wins.
  - if_req is ignored while if_flush is high.
  - Register the owner, addr, wr and wdata, then go to ISSUE. Stay in IDLE if no request wins.
- starve_cnt (4-bit): increments on every tie won by dm and saturates at STARVE_MAX. It clears whenever fetch is granted.
- ISSUE (1 cycle): drive mem_en=1 with mem_wr/mem_addr/mem_wdata from the registered values, and pulse the owner's grant. Load wait_cnt=LATENCY and go to WAIT.
- WAIT: decrement wait_cnt each cycle. In the cycle where wait_cnt==1, capture mem_rdata into the owner's rdata register (reads only) and go to DONE.
- DONE (1 cycle): pulse the owner's done, then go to IDLE.
  - Writes leave the rdata registers unchanged.
- Unaligned access (addr[0]==1): ISSUE keeps its timing but mem_en stays 0. DONE pulses done with err=1, and the owner's rdata reads 0x0000.
- Flush: if if_flush is high in any ISSUE or WAIT cycle of a fetch transaction, set cancel. While cancel is set:
  - the memory access still completes on the bus;
  - if_done is suppressed in DONE and if_rdata is not updated;
  - busy timing is unchanged.
  - cancel clears on entry to IDLE. if_flush has no effect on dm transactions.
- When not in ISSUE, mem_en=0, mem_wr=0, and mem_addr/mem_wdata hold their last values.
- Requesters hold req, addr, wr and wdata stable from assertion until their done cycle. They may change them in or after the done cycle.

## Timing
- Reset (asynchronous, rst low) forces immediately:
  - state=IDLE, starve_cnt=0, cancel=0;
  - mem_en, mem_wr, both grants, both dones, busy, err = 0;
  - mem_addr, mem_wdata, if_rdata, dm_rdata = 0x0000.
- Reset mid-transaction aborts it with no done pulse. The first request is sampled in the first clk edge after rst rises.
- Cycle-level transaction, with the request sampled in IDLE cycle N:
  - grant and mem_en in cycle N+1;
  - mem_rdata sampled at the end of cycle N+1+LATENCY;
  - done and rdata in cycle N+2+LATENCY;
  - IDLE again in cycle N+3+LATENCY.
- Throughput: one transaction per LATENCY+3 cycles under continuous requests.
- Simultaneous requests are resolved only in IDLE. The loser keeps requesting and is re-evaluated in the next IDLE cycle.
- A request that appears during ISSUE, WAIT or DONE waits for IDLE. Requests are never dropped.

## Test plan
- LATENCY=2, fetch read of 0x0010 from a memory holding 0xABCD, if_req rising in cycle 0 -> if_grant and mem_en=1 with mem_addr=0x0010 in cycle 1; if_done=1 and if_rdata=0xABCD in cycle 4; busy high in cycles 1-4.
- dm write of 0x1234 to 0x0020, then dm read of 0x0020 -> mem_wr=1 in the write's ISSUE cycle and dm_done 3 cycles later; the read returns dm_rdata=0x1234.
- if_req and dm_req both high in cycle 0 -> dm_grant in cycle 1, dm_done in cycle 4, if_grant in cycle 6, if_done in cycle 9.
- STARVE_MAX=4, both ports requesting continuously -> dm wins 4 consecutive ties, fetch wins the 5th, then dm wins the next tie with starve_cnt=0.
- Fetch issued in cycle 1, if_flush pulsed in cycle 2 -> no if_done in cycle 4, if_rdata unchanged, state IDLE in cycle 5.
- dm read of 0x0021 -> mem_en stays 0, dm_done=1 with err=1 and dm_rdata=0x0000 in cycle 4. Separately: rst asserted in cycle 2 of a transaction -> busy and mem_en drop immediately, no done pulse, and a new request is served normally after release.

Source files
------------

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Serialises instruction-fetch reads and data-memory reads/writes onto a single
// fixed-latency memory port. One transaction is outstanding at a time and runs
// IDLE -> ISSUE -> WAIT (LATENCY cycles) -> DONE -> IDLE.
//
// Arbitration happens only in IDLE. When both ports request, the data port
// wins, unless fetch has already lost STARVE_MAX ties in a row. In that case
// fetch wins the tie.
//
// A branch redirect (if_flush) during a fetch's ISSUE or WAIT cycles cancels
// the fetch. The bus access still completes, but the fetch requester gets no
// done pulse and keeps its old read data.
//
// An unaligned address (addr[0] == 1) is never put on the bus. The transaction
// keeps normal timing and completes with err=1 and read data 0x0000.
//
// Parameters
//   LATENCY     cycles from mem_en to valid mem_rdata (1..15)
//   STARVE_MAX  consecutive lost ties before fetch wins a tie (1..15)
//
// Ports
//   clk, rst                         clock (rising edge), async active-low reset
//   if_req/if_addr/if_flush          fetch request, address, squash
//   if_grant/if_done/if_rdata        fetch issue pulse, completion pulse, data
//   dm_req/dm_wr/dm_addr/dm_wdata    data request, direction, address, data
//   dm_grant/dm_done/dm_rdata        data issue pulse, completion pulse, data
//   mem_en/mem_wr/mem_addr/mem_wdata memory command port
//   mem_rdata                        memory read data, LATENCY cycles after mem_en
//   busy                             high whenever the FSM is not in IDLE
//   err                              unaligned-access flag, pulses with done
//
// All outputs are registered. Each output's next value is computed from the
// state being entered.
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int unsigned LATENCY    = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  input  logic        if_flush,
  output logic        if_grant,
  output logic        if_done,
  output logic [15:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_wr,
  input  logic [15:0] dm_addr,
  input  logic [15:0] dm_wdata,
  output logic        dm_grant,
  output logic        dm_done,
  output logic [15:0] dm_rdata,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [3:0] LAT_C    = 4'(LATENCY);
  localparam logic [3:0] STARVE_C = 4'(STARVE_MAX);

  // Address bit 0 set means a half-word-misaligned access.
  function automatic logic is_unaligned(input logic [15:0] addr);
    return addr[0];
  endfunction

  // Saturating increment of the starvation counter.
  function automatic logic [3:0] starve_inc(input logic [3:0] cnt);
    if (cnt >= STARVE_C) begin
      return STARVE_C;
    end else begin
      return cnt + 4'd1;
    end
  endfunction

  state_e      state_q, state_d;
  logic [3:0]  starve_q, starve_d;
  logic [3:0]  wait_q, wait_d;
  logic        cancel_q, cancel_d;
  logic        owner_if_q, owner_if_d;   // 1 = fetch owns the transaction
  logic        wr_q, wr_d;
  logic        unal_q, unal_d;
  logic        mem_en_q, mem_en_d;
  logic        mem_wr_q, mem_wr_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [15:0] mem_wdata_q, mem_wdata_d;
  logic        if_grant_q, if_grant_d;
  logic        dm_grant_q, dm_grant_d;
  logic        if_done_q, if_done_d;
  logic        dm_done_q, dm_done_d;
  logic [15:0] if_rdata_q, if_rdata_d;
  logic [15:0] dm_rdata_q, dm_rdata_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;

  logic        if_req_v;
  logic        cancel_now;

  // A fetch request raised together with a redirect is not a real request.
  assign if_req_v = if_req & ~if_flush;

  // The cancel decision includes a flush seen in the current ISSUE/WAIT cycle.
  // This lets a flush in the final WAIT cycle still suppress the done pulse.
  assign cancel_now = cancel_q | (owner_if_q & if_flush &
                      ((state_q == S_ISSUE) | (state_q == S_WAIT)));

  // Next-state and next-output logic for the arbitration FSM.
  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    wait_d      = wait_q;
    cancel_d    = cancel_q;
    owner_if_d  = owner_if_q;
    wr_d        = wr_q;
    unal_d      = unal_q;
    mem_en_d    = 1'b0;
    mem_wr_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_grant_d  = 1'b0;
    dm_grant_d  = 1'b0;
    if_done_d   = 1'b0;
    dm_done_d   = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    busy_d      = busy_q;
    err_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        cancel_d = 1'b0;
        if (dm_req && (!if_req_v || (starve_q != STARVE_C))) begin
          // The data port wins. If this was a tie, fetch lost one more round.
          state_d     = S_ISSUE;
          owner_if_d  = 1'b0;
          wr_d        = dm_wr;
          unal_d      = is_unaligned(dm_addr);
          mem_en_d    = ~is_unaligned(dm_addr);
          mem_wr_d    = dm_wr & ~is_unaligned(dm_addr);
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          dm_grant_d  = 1'b1;
          busy_d      = 1'b1;
          if (if_req_v) begin
            starve_d = starve_inc(starve_q);
          end else begin
            starve_d = starve_q;
          end
        end else if (if_req_v) begin
          // Fetch wins, either alone or through the starvation guard.
          state_d     = S_ISSUE;
          owner_if_d  = 1'b1;
          wr_d        = 1'b0;
          unal_d      = is_unaligned(if_addr);
          mem_en_d    = ~is_unaligned(if_addr);
          mem_wr_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = mem_wdata_q;
          if_grant_d  = 1'b1;
          busy_d      = 1'b1;
          starve_d    = 4'd0;
        end else begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end

      S_ISSUE: begin
        state_d  = S_WAIT;
        wait_d   = LAT_C;
        cancel_d = cancel_now;
        busy_d   = 1'b1;
      end

      S_WAIT: begin
        cancel_d = cancel_now;
        busy_d   = 1'b1;
        wait_d   = wait_q - 4'd1;
        if (wait_q <= 4'd1) begin
          // mem_rdata is valid in this cycle. Finish the transaction.
          state_d = S_DONE;
          if (owner_if_q) begin
            if (!cancel_now) begin
              if_done_d  = 1'b1;
              err_d      = unal_q;
              if_rdata_d = unal_q ? 16'h0000 : mem_rdata;
            end else begin
              if_rdata_d = if_rdata_q;
            end
          end else begin
            dm_done_d = 1'b1;
            err_d     = unal_q;
            if (unal_q) begin
              dm_rdata_d = 16'h0000;
            end else if (!wr_q) begin
              dm_rdata_d = mem_rdata;
            end else begin
              dm_rdata_d = dm_rdata_q;
            end
          end
        end else begin
          state_d = S_WAIT;
        end
      end

      S_DONE: begin
        state_d  = S_IDLE;
        cancel_d = 1'b0;
        busy_d   = 1'b0;
      end

      default: begin
        state_d  = S_IDLE;
        cancel_d = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  // State and registered-output flops. Reset aborts any transaction at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      starve_q    <= 4'd0;
      wait_q      <= 4'd0;
      cancel_q    <= 1'b0;
      owner_if_q  <= 1'b0;
      wr_q        <= 1'b0;
      unal_q      <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= 16'h0000;
      mem_wdata_q <= 16'h0000;
      if_grant_q  <= 1'b0;
      dm_grant_q  <= 1'b0;
      if_done_q   <= 1'b0;
      dm_done_q   <= 1'b0;
      if_rdata_q  <= 16'h0000;
      dm_rdata_q  <= 16'h0000;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      wait_q      <= wait_d;
      cancel_q    <= cancel_d;
      owner_if_q  <= owner_if_d;
      wr_q        <= wr_d;
      unal_q      <= unal_d;
      mem_en_q    <= mem_en_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_grant_q  <= if_grant_d;
      dm_grant_q  <= dm_grant_d;
      if_done_q   <= if_done_d;
      dm_done_q   <= dm_done_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign if_grant  = if_grant_q;
  assign if_done   = if_done_q;
  assign if_rdata  = if_rdata_q;
  assign dm_grant  = dm_grant_q;
  assign dm_done   = dm_done_q;
  assign dm_rdata  = dm_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter (LATENCY=2, STARVE_MAX=4). Drivers push the
// expected grant/done events into per-port queues. A monitor pops and compares
// them whenever the DUT shows a grant or done pulse.
module tb_mem_arbiter;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_flush, dm_req, dm_wr;
  logic [15:0] if_addr, dm_addr, dm_wdata;
  logic        if_grant, if_done, dm_grant, dm_done;
  logic [15:0] if_rdata, dm_rdata;
  logic        mem_en, mem_wr, busy, err;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int          cyc;
    logic [15:0] a;
    logic [15:0] b;
    logic        en;
    logic        wr;
    logic        err;
  } exp_t;

  exp_t ifg_q[$];
  exp_t dmg_q[$];
  exp_t ifd_q[$];
  exp_t dmd_q[$];

  mem_arbiter #(.LATENCY(LAT), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_grant(if_grant), .if_done(if_done), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_grant(dm_grant), .dm_done(dm_done), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model. Read data is valid only in the single cycle LATENCY after mem_en.
  logic [15:0] mem [0:255];
  logic [7:0]  rd_addr;
  int          rd_due;
  logic        rd_pend;

  function automatic logic [15:0] init_val(input int i);
    case (i)
      16'h0010: return 16'hABCD;
      16'h0040: return 16'h5555;
      16'h0042: return 16'h6666;
      default:  return 16'(i) ^ 16'h5A5A;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
      rd_pend <= 1'b0;
      rd_due  <= 0;
      rd_addr <= 8'h00;
    end else if (mem_en) begin
      if (mem_wr) begin
        mem[mem_addr[7:0]] <= mem_wdata;
      end else begin
        rd_addr <= mem_addr[7:0];
        rd_due  <= cyc + LAT;
        rd_pend <= 1'b1;
      end
    end
  end

  assign mem_rdata = (rd_pend && cyc == rd_due) ? mem[rd_addr] : 16'hDEAD;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk(input int c, input logic [15:0] a, input logic [15:0] b,
                              input logic en, input logic wr, input logic e);
    exp_t r;
    r.cyc = c; r.a = a; r.b = b; r.en = en; r.wr = wr; r.err = e;
    return r;
  endfunction

  task automatic check_grant(input string nm, input exp_t e);
    chk({nm, " cycle"}, 32'(cyc), 32'(e.cyc));
    chk({nm, " mem_en"}, 32'(mem_en), 32'(e.en));
    chk({nm, " mem_addr"}, 32'(mem_addr), 32'(e.a));
    chk({nm, " mem_wr"}, 32'(mem_wr), 32'(e.wr));
    if (e.wr) chk({nm, " mem_wdata"}, 32'(mem_wdata), 32'(e.b));
  endtask

  task automatic check_done(input string nm, input exp_t e, input logic [15:0] rd);
    chk({nm, " cycle"}, 32'(cyc), 32'(e.cyc));
    chk({nm, " rdata"}, 32'(rd), 32'(e.a));
    chk({nm, " err"}, 32'(err), 32'(e.err));
  endtask

  // Monitor: pops the matching expectation whenever a grant or done is seen.
  always @(negedge clk) begin
    if (rst) begin
      if (if_grant) begin
        if (ifg_q.size() == 0) chk("if_grant unexpected", 32'(if_grant), 32'd0);
        else check_grant("if_grant", ifg_q.pop_front());
      end
      if (dm_grant) begin
        if (dmg_q.size() == 0) chk("dm_grant unexpected", 32'(dm_grant), 32'd0);
        else check_grant("dm_grant", dmg_q.pop_front());
      end
      if (if_done) begin
        if (ifd_q.size() == 0) chk("if_done unexpected", 32'(if_done), 32'd0);
        else check_done("if_done", ifd_q.pop_front(), if_rdata);
      end
      if (dm_done) begin
        if (dmd_q.size() == 0) chk("dm_done unexpected", 32'(dm_done), 32'd0);
        else check_done("dm_done", dmd_q.pop_front(), dm_rdata);
      end
    end
  end

  // Single dm transaction starting in an IDLE cycle; returns in the next IDLE cycle.
  task automatic run_dm(input logic w, input logic [15:0] a, input logic [15:0] d,
                        input logic [15:0] exp_rd, input logic exp_err);
    int c0;
    c0 = cyc;
    dm_req = 1'b1; dm_wr = w; dm_addr = a; dm_wdata = d;
    dmg_q.push_back(mk(c0 + 1, a, d, ~a[0], w & ~a[0], 1'b0));
    dmd_q.push_back(mk(c0 + 2 + LAT, exp_rd, 16'h0000, 1'b0, 1'b0, exp_err));
    for (int i = 1; i <= LAT + 2; i++) begin
      @(negedge clk);
      chk("dm busy during transaction", 32'(busy), 32'd1);
    end
    dm_req = 1'b0;
    @(negedge clk);
    chk("dm busy after done", 32'(busy), 32'd0);
  endtask

  // Single fetch transaction starting in an IDLE cycle.
  task automatic run_if(input logic [15:0] a, input logic [15:0] exp_rd);
    int c0;
    c0 = cyc;
    if_req = 1'b1; if_addr = a;
    ifg_q.push_back(mk(c0 + 1, a, 16'h0000, ~a[0], 1'b0, 1'b0));
    ifd_q.push_back(mk(c0 + 2 + LAT, exp_rd, 16'h0000, 1'b0, 1'b0, a[0]));
    for (int i = 1; i <= LAT + 2; i++) begin
      @(negedge clk);
      chk("if busy during transaction", 32'(busy), 32'd1);
    end
    if_req = 1'b0;
    @(negedge clk);
    chk("if busy after done", 32'(busy), 32'd0);
  endtask

  initial begin
    int c0;
    rst = 1'b1;
    if_req = 1'b0; if_addr = 16'h0000; if_flush = 1'b0;
    dm_req = 1'b0; dm_wr = 1'b0; dm_addr = 16'h0000; dm_wdata = 16'h0000;
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);

    // Reset values
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset mem_en", 32'(mem_en), 32'd0);
    chk("reset mem_wr", 32'(mem_wr), 32'd0);
    chk("reset grants", 32'({if_grant, dm_grant}), 32'd0);
    chk("reset dones", 32'({if_done, dm_done}), 32'd0);
    chk("reset err", 32'(err), 32'd0);
    chk("reset mem_addr", 32'(mem_addr), 32'd0);
    chk("reset mem_wdata", 32'(mem_wdata), 32'd0);
    chk("reset if_rdata", 32'(if_rdata), 32'd0);
    chk("reset dm_rdata", 32'(dm_rdata), 32'd0);
    rst = 1'b1;

    // Fetch read, then dm write followed by dm read-back
    run_if(16'h0010, 16'hABCD);
    run_dm(1'b1, 16'h0020, 16'h1234, 16'h0000, 1'b0);
    run_dm(1'b0, 16'h0020, 16'h0000, 16'h1234, 1'b0);

    // Simultaneous requests: dm first, fetch in the following slot
    c0 = cyc;
    if_req = 1'b1; if_addr = 16'h0040;
    dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0042;
    dmg_q.push_back(mk(c0 + 1, 16'h0042, 16'h0000, 1'b1, 1'b0, 1'b0));
    dmd_q.push_back(mk(c0 + 4, 16'h6666, 16'h0000, 1'b0, 1'b0, 1'b0));
    ifg_q.push_back(mk(c0 + 6, 16'h0040, 16'h0000, 1'b1, 1'b0, 1'b0));
    ifd_q.push_back(mk(c0 + 9, 16'h5555, 16'h0000, 1'b0, 1'b0, 1'b0));
    repeat (4) @(negedge clk);
    dm_req = 1'b0;
    repeat (5) @(negedge clk);
    if_req = 1'b0;
    @(negedge clk);
    chk("tie busy after", 32'(busy), 32'd0);

    // Starvation guard: dm x4, fetch, dm (counter cleared), then fetch alone
    c0 = cyc;
    if_req = 1'b1; if_addr = 16'h0040;
    dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0042;
    for (int k = 0; k < 4; k++) begin
      dmg_q.push_back(mk(c0 + 1 + 5 * k, 16'h0042, 16'h0000, 1'b1, 1'b0, 1'b0));
      dmd_q.push_back(mk(c0 + 4 + 5 * k, 16'h6666, 16'h0000, 1'b0, 1'b0, 1'b0));
    end
    ifg_q.push_back(mk(c0 + 21, 16'h0040, 16'h0000, 1'b1, 1'b0, 1'b0));
    ifd_q.push_back(mk(c0 + 24, 16'h5555, 16'h0000, 1'b0, 1'b0, 1'b0));
    dmg_q.push_back(mk(c0 + 26, 16'h0042, 16'h0000, 1'b1, 1'b0, 1'b0));
    dmd_q.push_back(mk(c0 + 29, 16'h6666, 16'h0000, 1'b0, 1'b0, 1'b0));
    ifg_q.push_back(mk(c0 + 31, 16'h0040, 16'h0000, 1'b1, 1'b0, 1'b0));
    ifd_q.push_back(mk(c0 + 34, 16'h5555, 16'h0000, 1'b0, 1'b0, 1'b0));
    repeat (29) @(negedge clk);
    dm_req = 1'b0;
    repeat (5) @(negedge clk);
    if_req = 1'b0;
    @(negedge clk);

    // Flush during WAIT: bus access completes, no if_done, if_rdata kept
    c0 = cyc;
    if_req = 1'b1; if_addr = 16'h0010;
    ifg_q.push_back(mk(c0 + 1, 16'h0010, 16'h0000, 1'b1, 1'b0, 1'b0));
    repeat (2) @(negedge clk);
    if_flush = 1'b1; if_req = 1'b0;
    @(negedge clk);
    if_flush = 1'b0;
    @(negedge clk);
    chk("flush if_done suppressed", 32'(if_done), 32'd0);
    chk("flush if_rdata kept", 32'(if_rdata), 32'h5555);
    chk("flush busy in done slot", 32'(busy), 32'd1);
    @(negedge clk);
    chk("flush back to idle", 32'(busy), 32'd0);

    // Unaligned dm read
    run_dm(1'b0, 16'h0021, 16'h0000, 16'h0000, 1'b1);

    // Reset in the middle of a transaction
    c0 = cyc;
    dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0020;
    dmg_q.push_back(mk(c0 + 1, 16'h0020, 16'h0000, 1'b1, 1'b0, 1'b0));
    repeat (2) @(negedge clk);
    chk("pre-reset busy", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    chk("mid reset busy", 32'(busy), 32'd0);
    chk("mid reset mem_en", 32'(mem_en), 32'd0);
    chk("mid reset dm_rdata", 32'(dm_rdata), 32'd0);
    chk("mid reset if_rdata", 32'(if_rdata), 32'd0);
    dm_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("in reset no dm_done", 32'(dm_done), 32'd0);
    rst = 1'b1;
    run_if(16'h0010, 16'hABCD);

    repeat (3) @(negedge clk);
    chk("if_grant expectations left", 32'(ifg_q.size()), 32'd0);
    chk("dm_grant expectations left", 32'(dmg_q.size()), 32'd0);
    chk("if_done expectations left", 32'(ifd_q.size()), 32'd0);
    chk("dm_done expectations left", 32'(dmd_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
